// File: rtl/irq_ctrl_if.sv
// Bus between the single-cycle datapath (master) and the interrupt controller (slave).
// Carries request lines, mask/ie controls, and the take/vector/acknowledge results.
interface irq_ctrl_if;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_d;
    logic       ei;
    logic       di;
    logic       iret;
    logic       take;
    logic [9:0] vec;
    logic [3:0] ack;
    logic       busy;
    logic [3:0] pending;

    modport master (
        output irq, mask_we, mask_d, ei, di, iret,
        input  take, vec, ack, busy, pending
    );

    modport slave (
        input  irq, mask_we, mask_d, ei, di, iret,
        output take, vec, ack, busy, pending
    );
endinterface

// File: rtl/irq_ctrl.sv
// Four-line edge-triggered interrupt controller with fixed priority (line 0 highest).
// Define IRQ_CTRL_NEST_EN to allow preemption by strictly higher-priority lines via a 4-deep level stack.
module irq_ctrl (
    input  logic        clk,
    input  logic        reset,
    irq_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_TAKE, S_SERVICE} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_irq_q;
    logic [3:0] r_pending;
    logic [3:0] r_mask;
    logic       r_ie;
    logic [1:0] r_sel;
    logic [3:0] w_rise;
    logic [3:0] w_eligible;
    logic [3:0] w_ack;
    logic [1:0] w_winner;
    logic       w_any;

    assign w_rise     = bus.irq & ~r_irq_q;
    assign w_eligible = r_pending & ~r_mask & {4{r_ie}};
    assign w_any      = |w_eligible;

    // Outputs come from registered state and the latched winner only, never from irq.
    assign bus.take    = (r_state == S_TAKE);
    assign bus.vec     = bus.take ? (10'h3F0 + {6'd0, r_sel, 2'd0}) : 10'h000;
    assign w_ack       = bus.take ? (4'b0001 << r_sel) : 4'b0000;
    assign bus.ack     = w_ack;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.pending = r_pending;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        w_winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_eligible[i]) w_winner = 2'(i);
        end
    end

`ifdef IRQ_CTRL_NEST_EN
    logic [1:0] r_stack [4];
    logic [2:0] r_depth;
    logic [1:0] w_top;

    assign w_top = r_stack[r_depth[1:0] - 2'd1];
`else
    logic       r_ie_saved;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_any) w_state_nxt = S_TAKE;
            S_TAKE:    w_state_nxt = S_SERVICE;
            S_SERVICE: begin
`ifdef IRQ_CTRL_NEST_EN
                if (bus.iret) begin
                    if (r_depth == 3'd1) w_state_nxt = S_IDLE;
                end else if (w_any && (w_winner < w_top)) begin
                    w_state_nxt = S_TAKE;
                end
`else
                if (bus.iret) w_state_nxt = S_IDLE;
`endif
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_irq_q   <= 4'h0;
            r_pending <= 4'h0;
            r_mask    <= 4'hF;
            r_sel     <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_irq_q   <= bus.irq;
            // A fresh edge in the acknowledge cycle wins over the clear.
            r_pending <= (r_pending & ~w_ack) | w_rise;
            if (bus.mask_we) r_mask <= bus.mask_d;
            if (w_state_nxt == S_TAKE) r_sel <= w_winner;
        end
    end

    // Explicit ei/di in any cycle, including TAKE, overrides the automatic ie handling.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ie <= 1'b0;
`ifndef IRQ_CTRL_NEST_EN
            r_ie_saved <= 1'b0;
`endif
        end else begin
`ifndef IRQ_CTRL_NEST_EN
            if (r_state == S_TAKE) r_ie_saved <= r_ie;
`endif
            if (bus.di) begin
                r_ie <= 1'b0;
            end else if (bus.ei) begin
                r_ie <= 1'b1;
`ifndef IRQ_CTRL_NEST_EN
            end else if (r_state == S_TAKE) begin
                r_ie <= 1'b0;
            end else if ((r_state == S_SERVICE) && bus.iret) begin
                r_ie <= r_ie_saved;
`endif
            end
        end
    end

`ifdef IRQ_CTRL_NEST_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_depth <= 3'd0;
        end else if (r_state == S_TAKE) begin
            r_depth <= r_depth + 3'd1;
        end else if ((r_state == S_SERVICE) && bus.iret) begin
            r_depth <= r_depth - 3'd1;
        end
    end

    // NOTE: stack entries carry no reset; r_depth alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (r_state == S_TAKE) r_stack[r_depth[1:0]] <= r_sel;
    end
`endif
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-low reset, with ports named clk and reset.
REQ-002 clk  in  1  rising-edge clock shared with the single-cycle datapath.
REQ-003 reset  in  1  synchronous active-low reset, sampled on rising clk.
REQ-004 irq  in  4  interrupt request lines, level inputs, edge-detected internally; index 0 is highest priority.
REQ-005 mask_we  in  1  load mask register from mask_d.
REQ-006 mask_d  in  4  new mask value; 1 means masked.
REQ-007 ei  in  1  decoded enable-interrupts instruction.
REQ-008 di  in  1  decoded disable-interrupts instruction.
REQ-009 iret  in  1  decoded return-from-interrupt instruction; the datapath pops the stack in the same cycle.
REQ-010 take  out  1  one-cycle strobe: datapath pushes return address and loads PC from vec.
REQ-011 vec  out  10  vector address, 10'h3F0 + 4*idx; 10'h000 when take=0.
REQ-012 ack  out  4  one-hot acknowledge of the serviced line, valid only while take=1.
REQ-013 busy  out  1  high while at least one interrupt is in service.
REQ-014 pending  out  4  latched, not-yet-acknowledged requests.

Function
REQ-015 Edge detect SHALL be: irq_q <= irq each cycle; pending[i] is set when irq[i] & ~irq_q[i].
REQ-016 pending[i] SHALL be cleared at the end of the cycle in which ack[i]=1; a new edge in that same cycle keeps the bit set.
REQ-017 eligible SHALL be pending & ~mask & {4{ie}}; the winner is the lowest set index.
REQ-018 The FSM SHALL have exactly three states: IDLE, TAKE and SERVICE.
REQ-019 IDLE -> TAKE when eligible != 0; otherwise the FSM stays in IDLE.
REQ-020 In TAKE, take, vec and ack SHALL be asserted for exactly one cycle, the winner index is recorded as the current level, and the next state is SERVICE.
REQ-021 Latency: an irq first sampled high at edge k SHALL produce take=1 during the cycle after edge k+1.
REQ-022 TAKE SHALL clear ie, saving its previous value; iret in SERVICE SHALL restore ie and return to IDLE.
REQ-023 iret in IDLE or TAKE SHALL be ignored.
REQ-024 When ei and di are asserted together, di SHALL win; ei/di SHALL take effect on the next edge, and a write in the TAKE cycle overrides the automatic ie clear.
REQ-025 mask_we SHALL update the mask at the next edge; a masked pending bit is retained, not dropped.
REQ-026 busy SHALL be 1 in TAKE and in SERVICE.
REQ-027 Outputs take, vec and ack SHALL be decoded from registered state only, with no combinational path from irq.

Reset
REQ-028 On reset=0 at a rising edge: state=IDLE, pending=0, irq_q=0, mask=4'hF, ie=0, level stack empty, take=0, vec=0, ack=0, busy=0.
REQ-029 Reset asserted in TAKE or SERVICE SHALL abandon service with no further take; the outstanding iret is ignored afterwards.

Configuration
REQ-030 Macro IRQ_CTRL_NEST_EN SHALL control nesting.
- Defined: TAKE does not clear ie.
- In SERVICE, an eligible index strictly lower than the current level re-enters TAKE (preemption).
- A 4-deep level stack records each level.
- iret pops the stack; the FSM returns to IDLE only when the stack empties.
- Equal or lower priority waits in pending.
REQ-031 Without IRQ_CTRL_NEST_EN, SERVICE SHALL ignore all pending requests until iret, and no level stack is built.

Verification
REQ-032 Reset release, ei, mask_we with mask_d=4'h0, irq[2] pulsed high -> two edges later take=1, ack=4'b0100, vec=10'h3F8 for one cycle, busy=1.
REQ-033 irq=4'b1010 rising in the same cycle -> ack=4'b0010, vec=10'h3F4; after iret and 1 cycle, ack=4'b1000, vec=10'h3FC.
REQ-034 mask=4'b0001, irq[0] pulse -> no take; pending=4'b0001 held; mask_we with 4'h0 -> take with vec=10'h3F0 two cycles later.
REQ-035 Without nesting, in SERVICE of line 3 pulse irq[0] -> no take until iret; then take vec=10'h3F0. With IRQ_CTRL_NEST_EN -> immediate take vec=10'h3F0; two irets return to IDLE, busy=0.
REQ-036 reset=0 for one cycle during SERVICE with pending=4'b0100 -> pending=0, busy=0, mask=4'hF, no take afterwards; a subsequent iret has no effect.
